// File: rtl/rpn_controle_pilha.sv
// RPN operand stack controller: pushes operands, issues top-two operands to the ALU or
// a multi-cycle unit and writes the result back. Optional WAIT timeout: RPN_TIMEOUT_MULT_EN.
module rpn_controle_pilha #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OPW   = 3,
    parameter logic [2**OPW-1:0] MULTI_MASK = 8'b0000_0100
`ifdef RPN_TIMEOUT_MULT_EN
    , parameter int TIMEOUT = 64
`endif
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    input  logic                       Enter,
    input  logic                       Modo,
    input  logic [WIDTH-1:0]           Dado,
    input  logic [OPW-1:0]             Op,
    input  logic                       Carry,
    input  logic                       Limpar,
    input  logic [WIDTH-1:0]           ResultadoULA,
    input  logic [WIDTH-1:0]           ResultadoMult,
    input  logic                       ProntoMult,
    output logic [WIDTH-1:0]           OperandoA,
    output logic [WIDTH-1:0]           OperandoB,
    output logic [OPW-1:0]             RegOp,
    output logic                       RegCarry,
    output logic                       StartMult,
    output logic                       SelResultado,
    output logic                       AguardandoMult,
    output logic                       LoadResultado,
    output logic [WIDTH-1:0]           Topo,
    output logic [$clog2(DEPTH+1)-1:0] Nivel,
    output logic [1:0]                 Erro
);
    localparam int NW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);
    localparam logic [NW-1:0] DOIS    = NW'(2);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;
    state_t state, state_n;

    logic [DEPTH-1:0][WIDTH-1:0] pilha;
    logic [AW-1:0] sp1, sp2, sp0;
    logic [WIDTH-1:0] res;
    logic do_push, do_ovf, do_unf, do_acc, do_wb, do_tmo;

    assign sp0 = AW'(Nivel);
    assign sp1 = AW'(Nivel - NW'(1));
    assign sp2 = AW'(Nivel - DOIS);
    assign res = SelResultado ? ResultadoMult : ResultadoULA;
    assign Topo = (Nivel == '0) ? '0 : pilha[sp1];
    assign AguardandoMult = (state == WAIT);

`ifdef RPN_TIMEOUT_MULT_EN
    localparam int CW = $clog2(TIMEOUT+1);
    logic [CW-1:0] tmo_cnt;
    // Counts WAIT cycles starting with the StartMult cycle
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)              tmo_cnt <= '0;
        else if (do_acc)           tmo_cnt <= '0;
        else if (state == WAIT)    tmo_cnt <= tmo_cnt + CW'(1);
    end
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        do_push = 1'b0;
        do_ovf  = 1'b0;
        do_unf  = 1'b0;
        do_acc  = 1'b0;
        do_wb   = 1'b0;
        do_tmo  = 1'b0;
        if (Limpar) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: if (Enter) begin
                    if (!Modo) begin
                        if (Nivel < DEPTH_N) do_push = 1'b1;
                        else                 do_ovf  = 1'b1;
                    end else if (Nivel < DOIS) begin
                        do_unf = 1'b1;
                    end else begin
                        do_acc  = 1'b1;
                        state_n = MULTI_MASK[Op] ? WAIT : EXEC;
                    end
                end
                EXEC: begin
                    do_wb   = 1'b1;
                    state_n = IDLE;
                end
                WAIT: begin
                    // A done pulse in the StartMult cycle belongs to no operation of ours
                    if (ProntoMult && !StartMult) begin
                        do_wb   = 1'b1;
                        state_n = IDLE;
                    end
`ifdef RPN_TIMEOUT_MULT_EN
                    else if (tmo_cnt == CW'(TIMEOUT-1)) begin
                        do_tmo  = 1'b1;
                        state_n = IDLE;
                    end
`endif
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pilha         <= '0;
            Nivel         <= '0;
            Erro          <= 2'b00;
            OperandoA     <= '0;
            OperandoB     <= '0;
            RegOp         <= '0;
            RegCarry      <= 1'b0;
            StartMult     <= 1'b0;
            SelResultado  <= 1'b0;
            LoadResultado <= 1'b0;
        end else begin
            StartMult     <= 1'b0;
            LoadResultado <= 1'b0;
            if (Limpar) begin
                Nivel        <= '0;
                Erro         <= 2'b00;
                SelResultado <= 1'b0;
            end else begin
                if (do_push) begin
                    pilha[sp0] <= Dado;
                    Nivel      <= Nivel + NW'(1);
                    Erro       <= 2'b00;
                end
                if (do_ovf) Erro <= 2'b01;
                if (do_unf) Erro <= 2'b10;
                if (do_acc) begin
                    OperandoA    <= pilha[sp2];
                    OperandoB    <= pilha[sp1];
                    RegOp        <= Op;
                    RegCarry     <= Carry;
                    Erro         <= 2'b00;
                    SelResultado <= MULTI_MASK[Op];
                    StartMult    <= MULTI_MASK[Op];
                end
                // Result replaces the lower operand; the upper one is popped
                if (do_wb) begin
                    pilha[sp2]    <= res;
                    Nivel         <= Nivel - NW'(1);
                    LoadResultado <= 1'b1;
                    SelResultado  <= 1'b0;
                end
                if (do_tmo) begin
                    Erro         <= 2'b11;
                    SelResultado <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rpn_controle_pilha.sv
// Directed bench for rpn_controle_pilha (DEPTH=4, WIDTH=8).
module tb_rpn_controle_pilha;
    logic       Clock = 1'b0, Reset_n = 1'b0;
    logic       Enter = 0, Modo = 0, Carry = 0, Limpar = 0, ProntoMult = 0;
    logic [7:0] Dado = 0, ResultadoULA = 0, ResultadoMult = 0;
    logic [2:0] Op = 0;
    logic [7:0] OperandoA, OperandoB, Topo;
    logic [2:0] RegOp, Nivel;
    logic       RegCarry, StartMult, SelResultado, AguardandoMult, LoadResultado;
    logic [1:0] Erro;
    int n_chk = 0, n_fail = 0;

    always #5 Clock = ~Clock;

    rpn_controle_pilha #(
        .WIDTH(8), .DEPTH(4), .OPW(3)
`ifdef RPN_TIMEOUT_MULT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Enter(Enter), .Modo(Modo), .Dado(Dado),
        .Op(Op), .Carry(Carry), .Limpar(Limpar), .ResultadoULA(ResultadoULA),
        .ResultadoMult(ResultadoMult), .ProntoMult(ProntoMult), .OperandoA(OperandoA),
        .OperandoB(OperandoB), .RegOp(RegOp), .RegCarry(RegCarry), .StartMult(StartMult),
        .SelResultado(SelResultado), .AguardandoMult(AguardandoMult),
        .LoadResultado(LoadResultado), .Topo(Topo), .Nivel(Nivel), .Erro(Erro)
    );

    task automatic tick();
        @(posedge Clock); #1;
    endtask

    task automatic push(input logic [7:0] d);
        Enter = 1; Modo = 0; Dado = d; tick(); Enter = 0;
    endtask

    task automatic oper(input logic [2:0] o);
        Enter = 1; Modo = 1; Op = o; tick(); Enter = 0; Modo = 0;
    endtask

    task automatic clear();
        Limpar = 1; tick(); Limpar = 0;
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if ({OperandoA, OperandoB, RegOp, RegCarry, StartMult, SelResultado, AguardandoMult,
             LoadResultado, Topo, Nivel, Erro} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got A=%0d B=%0d Topo=%0d Nivel=%0d Erro=%0d exp all 0",
                               OperandoA, OperandoB, Topo, Nivel, Erro);
        end
        #10 Reset_n = 1; tick();
    endtask

    task automatic test_add();
        push(5); push(3);
        n_chk++; if (Nivel !== 3'd2 || Topo !== 8'd3) begin n_fail++;
            $display("FAIL add_push got Nivel=%0d Topo=%0d exp 2 3", Nivel, Topo); end
        ResultadoULA = 8; Carry = 1;
        oper(3'b000);
        n_chk++; if (OperandoA !== 8'd5 || OperandoB !== 8'd3 || RegOp !== 3'd0 || RegCarry !== 1'b1
                     || StartMult !== 1'b0 || LoadResultado !== 1'b0 || SelResultado !== 1'b0) begin n_fail++;
            $display("FAIL add_latch got A=%0d B=%0d op=%0d c=%0b st=%0b ld=%0b sel=%0b exp 5 3 0 1 0 0 0",
                     OperandoA, OperandoB, RegOp, RegCarry, StartMult, LoadResultado, SelResultado); end
        Carry = 0;
        tick();
        n_chk++; if (LoadResultado !== 1'b1 || Topo !== 8'd8 || Nivel !== 3'd1) begin n_fail++;
            $display("FAIL add_wb got ld=%0b Topo=%0d Nivel=%0d exp 1 8 1", LoadResultado, Topo, Nivel); end
        tick();
        n_chk++; if (LoadResultado !== 1'b0) begin n_fail++;
            $display("FAIL add_ld_pulse got %0b exp 0", LoadResultado); end
        clear();
    endtask

    task automatic test_mult();
        push(4); push(6);
        oper(3'b010);
        n_chk++; if (StartMult !== 1'b1 || AguardandoMult !== 1'b1 || SelResultado !== 1'b1
                     || OperandoA !== 8'd4 || OperandoB !== 8'd6) begin n_fail++;
            $display("FAIL mult_start got st=%0b wait=%0b sel=%0b A=%0d B=%0d exp 1 1 1 4 6",
                     StartMult, AguardandoMult, SelResultado, OperandoA, OperandoB); end
        tick();
        n_chk++; if (StartMult !== 1'b0 || AguardandoMult !== 1'b1) begin n_fail++;
            $display("FAIL mult_wait got st=%0b wait=%0b exp 0 1", StartMult, AguardandoMult); end
        push(99);
        n_chk++; if (Nivel !== 3'd2 || Erro !== 2'b00 || AguardandoMult !== 1'b1) begin n_fail++;
            $display("FAIL mult_enter_drop got Nivel=%0d Erro=%0d wait=%0b exp 2 0 1", Nivel, Erro, AguardandoMult); end
        ResultadoMult = 24; ProntoMult = 1; tick(); ProntoMult = 0;
        n_chk++; if (LoadResultado !== 1'b1 || Topo !== 8'd24 || Nivel !== 3'd1
                     || AguardandoMult !== 1'b0 || SelResultado !== 1'b0) begin n_fail++;
            $display("FAIL mult_done got ld=%0b Topo=%0d Nivel=%0d wait=%0b sel=%0b exp 1 24 1 0 0",
                     LoadResultado, Topo, Nivel, AguardandoMult, SelResultado); end
        clear();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) push(8'(i));
        n_chk++; if (Nivel !== 3'd4 || Topo !== 8'd4 || Erro !== 2'b00) begin n_fail++;
            $display("FAIL ovf_full got Nivel=%0d Topo=%0d Erro=%0d exp 4 4 0", Nivel, Topo, Erro); end
        push(5);
        n_chk++; if (Nivel !== 3'd4 || Topo !== 8'd4 || Erro !== 2'b01) begin n_fail++;
            $display("FAIL ovf_err got Nivel=%0d Topo=%0d Erro=%0d exp 4 4 1", Nivel, Topo, Erro); end
        tick();
        n_chk++; if (Erro !== 2'b01) begin n_fail++;
            $display("FAIL ovf_sticky got %0d exp 1", Erro); end
        ResultadoULA = 7; oper(3'b000); tick();
        n_chk++; if (Nivel !== 3'd3 || Topo !== 8'd7 || Erro !== 2'b00) begin n_fail++;
            $display("FAIL ovf_pop got Nivel=%0d Topo=%0d Erro=%0d exp 3 7 0", Nivel, Topo, Erro); end
        push(9);
        n_chk++; if (Nivel !== 3'd4 || Topo !== 8'd9 || Erro !== 2'b00) begin n_fail++;
            $display("FAIL ovf_repush got Nivel=%0d Topo=%0d Erro=%0d exp 4 9 0", Nivel, Topo, Erro); end
        clear();
    endtask

    task automatic test_underflow();
        push(7);
        oper(3'b010);
        n_chk++; if (Erro !== 2'b10 || Nivel !== 3'd1 || StartMult !== 1'b0 || AguardandoMult !== 1'b0) begin n_fail++;
            $display("FAIL unf_err got Erro=%0d Nivel=%0d st=%0b wait=%0b exp 2 1 0 0",
                     Erro, Nivel, StartMult, AguardandoMult); end
        push(8);
        n_chk++; if (Erro !== 2'b00 || Nivel !== 3'd2 || Topo !== 8'd8) begin n_fail++;
            $display("FAIL unf_clear got Erro=%0d Nivel=%0d Topo=%0d exp 0 2 8", Erro, Nivel, Topo); end
        clear();
        n_chk++; if (Nivel !== 3'd0 || Topo !== 8'd0) begin n_fail++;
            $display("FAIL limpar got Nivel=%0d Topo=%0d exp 0 0", Nivel, Topo); end
    endtask

    task automatic test_limpar_wait();
        push(2); push(3); oper(3'b010); tick();
        Limpar = 1; ProntoMult = 1; ResultadoMult = 55; tick(); Limpar = 0; ProntoMult = 0;
        n_chk++; if (Nivel !== 3'd0 || AguardandoMult !== 1'b0 || LoadResultado !== 1'b0 || Topo !== 8'd0) begin n_fail++;
            $display("FAIL limpar_wait got Nivel=%0d wait=%0b ld=%0b Topo=%0d exp 0 0 0 0",
                     Nivel, AguardandoMult, LoadResultado, Topo); end
        tick();
        n_chk++; if (LoadResultado !== 1'b0 || Nivel !== 3'd0) begin n_fail++;
            $display("FAIL limpar_wait_after got ld=%0b Nivel=%0d exp 0 0", LoadResultado, Nivel); end
    endtask

    task automatic test_reset_mid_wait();
        push(2); push(3); oper(3'b010); tick();
        #1 Reset_n = 0; #1;
        n_chk++; if ({OperandoA, OperandoB, StartMult, SelResultado, AguardandoMult, LoadResultado,
                      Topo, Nivel, Erro} !== '0) begin n_fail++;
            $display("FAIL reset_wait got A=%0d B=%0d wait=%0b sel=%0b Topo=%0d Nivel=%0d exp all 0",
                     OperandoA, OperandoB, AguardandoMult, SelResultado, Topo, Nivel); end
        Reset_n = 1;
        ProntoMult = 1; ResultadoMult = 77; tick(); ProntoMult = 0;
        n_chk++; if (LoadResultado !== 1'b0 || Nivel !== 3'd0 || Topo !== 8'd0) begin n_fail++;
            $display("FAIL stray_pronto got ld=%0b Nivel=%0d Topo=%0d exp 0 0 0", LoadResultado, Nivel, Topo); end
    endtask

    task automatic test_timeout();
        push(10); push(20); oper(3'b010);
`ifdef RPN_TIMEOUT_MULT_EN
        repeat (7) tick();
        n_chk++; if (AguardandoMult !== 1'b1 || Erro !== 2'b00) begin n_fail++;
            $display("FAIL tmo_early got wait=%0b Erro=%0d exp 1 0", AguardandoMult, Erro); end
        tick();
        n_chk++; if (AguardandoMult !== 1'b0 || Erro !== 2'b11 || Nivel !== 3'd2 || Topo !== 8'd20
                     || LoadResultado !== 1'b0) begin n_fail++;
            $display("FAIL tmo_fire got wait=%0b Erro=%0d Nivel=%0d Topo=%0d ld=%0b exp 0 3 2 20 0",
                     AguardandoMult, Erro, Nivel, Topo, LoadResultado); end
`else
        repeat (100) tick();
        n_chk++; if (AguardandoMult !== 1'b1 || Erro !== 2'b00 || Nivel !== 3'd2) begin n_fail++;
            $display("FAIL no_tmo got wait=%0b Erro=%0d Nivel=%0d exp 1 0 2", AguardandoMult, Erro, Nivel); end
        ResultadoMult = 200; ProntoMult = 1; tick(); ProntoMult = 0;
        n_chk++; if (Topo !== 8'd200 || Nivel !== 3'd1 || LoadResultado !== 1'b1) begin n_fail++;
            $display("FAIL no_tmo_done got Topo=%0d Nivel=%0d ld=%0b exp 200 1 1", Topo, Nivel, LoadResultado); end
`endif
        clear();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mult();
        test_overflow();
        test_underflow();
        test_limpar_wait();
        test_reset_mid_wait();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rpn_controle_pilha.md
Name: rpn_controle_pilha

Overview:
Parametrised successor to the fixed 4-step RPN decoder. It holds a DEPTH-entry operand stack and accepts operand pushes and operator entries one Enter at a time. It drives the top two stack entries to the ALU and multi-cycle units, waits for multi-cycle completion with a start/ready handshake, and writes the result back onto the stack. It sits between the input/debounce logic and the ALU/multiplier datapath.

Parameters:
WIDTH, 8, operand/result width in bits
DEPTH, 4, stack entries (>=2)
OPW, 3, operator code width
MULTI_MASK, 8'b0000_0100, bit k set -> opcode k is multi-cycle (default: 010 = multiplication); width 2**OPW

Ports:
Clock  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
Enter  in  1  single-cycle pulse, already edge-detected
Modo  in  1  0 = push Dado, 1 = apply Op
Dado  in  WIDTH  operand to push
Op  in  OPW  operator code
Carry  in  1  carry-in for the operation
Limpar  in  1  synchronous stack clear
ResultadoULA  in  WIDTH  combinational ALU result
ResultadoMult  in  WIDTH  multi-cycle unit result
ProntoMult  in  1  multi-cycle unit done, single-cycle pulse
OperandoA  out  WIDTH  stack[sp-2], registered at operator accept
OperandoB  out  WIDTH  stack[sp-1], registered at operator accept
RegOp  out  OPW  latched operator
RegCarry  out  1  latched carry
StartMult  out  1  one-cycle start pulse to the multi-cycle unit
SelResultado  out  1  0 = ALU, 1 = multi-cycle unit
AguardandoMult  out  1  high while in WAIT
LoadResultado  out  1  one-cycle pulse on result writeback
Topo  out  WIDTH  current top of stack (0 when empty)
Nivel  out  clog2(DEPTH+1)  entries in use
Erro  out  2  00 none, 01 overflow, 10 underflow, 11 timeout

Behaviour:
- Reset (asynchronous): all outputs 0, Nivel = 0, stack contents 0, state IDLE.
- States: IDLE, EXEC, WAIT.
- IDLE, Enter with Modo=0:
  - Nivel<DEPTH: push Dado, Nivel+1, Erro<=00.
  - Nivel==DEPTH: no change to the stack, Erro<=01.
- IDLE, Enter with Modo=1:
  - Nivel<2: Erro<=10, stay in IDLE.
  - Otherwise: latch OperandoA/B, RegOp, RegCarry; Erro<=00. Set SelResultado = MULTI_MASK[Op].
  - Multi-cycle op: StartMult pulses the same cycle the registers update, then go to WAIT.
  - Single-cycle op: go to EXEC.
- EXEC (exactly 1 cycle): capture ResultadoULA into stack[sp-2], Nivel-1, LoadResultado=1, back to IDLE. Operator-to-writeback latency is 2 cycles.
- WAIT: AguardandoMult=1. On ProntoMult, capture ResultadoMult as in EXEC, pulse LoadResultado, go to IDLE, SelResultado<=0. ProntoMult in the same cycle as entering WAIT is ignored.
- Enter in EXEC or WAIT is dropped (not queued) and causes no error.
- Limpar, in any state: Nivel<=0, Topo=0, Erro<=00, StartMult=0, state IDLE. Limpar has priority over Enter and ProntoMult in the same cycle.
- ProntoMult outside WAIT is ignored.
- Reset asserted mid-WAIT aborts the operation immediately. A later stray ProntoMult is ignored.
- Stack depth boundaries: pushes up to DEPTH succeed and the next push overflows. A result writeback never overflows, since Nivel decreases.
- Erro is sticky until the next accepted Enter or Limpar.

Optional Feature:
- Macro: RPN_TIMEOUT_MULT_EN.
- Adds parameter TIMEOUT (default 64).
- With the macro: a WAIT cycle counter counts from StartMult. If TIMEOUT cycles pass without ProntoMult, go to IDLE with the stack unchanged (operands not popped), Erro<=11, no LoadResultado.
- Without the macro: WAIT lasts indefinitely and Erro never takes 11.

Test Plan:
- Reset, then push 5 and 3, then Op=000 (add) with ResultadoULA=8 -> LoadResultado pulses 2 cycles after the operator Enter; Topo=8, Nivel=1.
- Push 4 and 6, then Op=010 -> StartMult pulses 1 cycle, AguardandoMult=1, SelResultado=1. Extra Enter during WAIT is ignored. ProntoMult with ResultadoMult=24 -> Topo=24, Nivel=1, AguardandoMult=0.
- DEPTH=4: push 1,2,3,4,5 -> 5th push gives Erro=01, Nivel=4, Topo=4. Next accepted push after a pop clears Erro.
- One operand on the stack, then Op Enter -> Erro=10, Nivel=1, no StartMult.
- Limpar and ProntoMult in the same WAIT cycle -> Nivel=0, state IDLE, LoadResultado=0. Reset_n low mid-WAIT -> all outputs 0 asynchronously.
- With RPN_TIMEOUT_MULT_EN and TIMEOUT=8: Op=010 with no ProntoMult -> after 8 cycles Erro=11, Nivel=2, operands intact.
